device_memory_responder: RTL

//  Device-side endpoint of the banked device bus: accepts request/write/address/data from the bank arbiter,

---
 rtl/device_memory_responder_pkg.sv | 16 +
 rtl/device_read_pipeline.sv | 38 +++
 rtl/device_memory_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/device_memory_responder_pkg.sv
// Shared types and constants for the device memory responder.
package device_memory_responder_pkg;

  // Refresh controller state; the pending phase is a flag inside IDLE.
  typedef enum logic {
    IDLE    = 1'b0,
    REFRESH = 1'b1
  } state_t;

  // Byte address bits below this index select a byte inside a 32-bit word.
  localparam int WORD_LSB = 2;

  // Width of the optional accepted-read/write statistics counters.
  localparam int STATS_WIDTH = 16;

endpackage

// File: rtl/device_read_pipeline.sv
// Valid/data shift register that delays read responses by DEPTH cycles.
// Valid bits clear synchronously; data bits are don't-care while invalid.
module device_read_pipeline #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift the valid bits; clear discards every in-flight response.
  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Shift the data alongside; no clear needed because valid qualifies it.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/device_memory_responder.sv
// Device-side memory endpoint of the banked device bus.
// Synchronous single-port RAM, fixed-latency read responses and periodic
// maintenance windows that hold requests off through o_busy.
// Optional statistics counters: define DEVICE_MEMORY_RESPONDER_STATS_EN.
module device_memory_responder
  import device_memory_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 26,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int READ_LATENCY      = 3,
  parameter int REFRESH_INTERVAL  = 1024,
  parameter int REFRESH_CYCLES    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_request,
  input  logic                     i_write,
  output logic                     o_busy,
  output logic                     o_ack,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [31:0]              i_data,
  output logic [31:0]              o_data
`ifdef DEVICE_MEMORY_RESPONDER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]   o_read_count,
  output logic [STATS_WIDTH-1:0]   o_write_count
`endif
);

  localparam int MEM_DEPTH = 2 ** MEM_ADDRESS_WIDTH;
  localparam int IW        = $clog2(REFRESH_INTERVAL);
  localparam int RW        = $clog2(REFRESH_CYCLES + 1);
  localparam logic [IW-1:0] INTERVAL_RELOAD = IW'(REFRESH_INTERVAL - 1);
  localparam logic [RW-1:0] REFRESH_RELOAD  = RW'(REFRESH_CYCLES - 1);

  // ---------------------------------------------------------------- refresh
  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic [IW-1:0]   interval_q, interval_d;
  logic [RW-1:0]   refresh_q, refresh_d;

  // Refresh controller state registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      interval_q <= INTERVAL_RELOAD;
      refresh_q  <= REFRESH_RELOAD;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      interval_q <= interval_d;
      refresh_q  <= refresh_d;
    end
  end

  // Next state: count down the interval, raise pending, run the window.
  // NOTE: every always_comb output is defaulted first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    interval_d = interval_q;
    refresh_d  = refresh_q;
    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = REFRESH;
          refresh_d = REFRESH_RELOAD;
        end else if (interval_q == '0) begin
          pending_d = 1'b1;
        end else begin
          interval_d = interval_q - IW'(1);
        end
      end
      REFRESH: begin
        if (refresh_q == '0) begin
          state_d    = IDLE;
          pending_d  = 1'b0;
          interval_d = INTERVAL_RELOAD;
        end else begin
          refresh_d = refresh_q - RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = pending_q || (state_q == REFRESH);

  // ---------------------------------------------------------------- memory
  logic                         accept, accept_read, accept_write;
  logic [MEM_ADDRESS_WIDTH-1:0] word_index;
  logic [31:0]                  mem [MEM_DEPTH];
  logic [31:0]                  rd_data_q;
  logic                         rd_valid_q;
  logic                         unused_address;

  // A request is never taken while reset is asserted, so memory survives reset.
  assign accept       = i_request && !o_busy && !i_reset;
  assign accept_read  = accept && !i_write;
  assign accept_write = accept && i_write;
  assign word_index   = i_address[MEM_ADDRESS_WIDTH+WORD_LSB-1:WORD_LSB];
  assign unused_address = ^{i_address[ADDRESS_WIDTH-1:MEM_ADDRESS_WIDTH+WORD_LSB],
                            i_address[WORD_LSB-1:0]};

  // Single-port synchronous RAM: write or registered read at the accept edge.
  // NOTE: the array has no reset so it maps onto block RAM; contents persist across i_reset.
  always_ff @(posedge i_clk) begin
    if (accept_write) mem[word_index] <= i_data;
    if (accept_read)  rd_data_q       <= mem[word_index];
  end

  // RAM output stage valid flag; counts as the first cycle of read latency.
  always_ff @(posedge i_clk) begin
    if (i_reset) rd_valid_q <= 1'b0;
    else         rd_valid_q <= accept_read;
  end

  // ---------------------------------------------------------------- response
  logic        resp_valid;
  logic [31:0] resp_data;

  generate
    if (READ_LATENCY > 1) begin : g_pipe
      device_read_pipeline #(
        .DEPTH (READ_LATENCY - 1),
        .WIDTH (32)
      ) u_read_pipeline (
        .clk       (i_clk),
        .clear     (i_reset),
        .in_valid  (rd_valid_q),
        .in_data   (rd_data_q),
        .out_valid (resp_valid),
        .out_data  (resp_data)
      );
    end else begin : g_direct
      assign resp_valid = rd_valid_q;
      assign resp_data  = rd_data_q;
    end
  endgenerate

  // Data is forced to zero outside an ack so the bus never shows stale words.
  assign o_ack  = resp_valid;
  assign o_data = resp_valid ? resp_data : 32'h0;

`ifdef DEVICE_MEMORY_RESPONDER_STATS_EN
  // Saturating counters of accepted reads and writes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_read_count  <= '0;
      o_write_count <= '0;
    end else begin
      if (accept_read && (o_read_count != '1))   o_read_count  <= o_read_count + 1'b1;
      if (accept_write && (o_write_count != '1)) o_write_count <= o_write_count + 1'b1;
    end
  end
`endif

endmodule
